// File: rtl/result_reader4.sv
// ----------------------------------------------------------------------------
// result_reader4
// Read side of the FC1 result storage. The block walks a requested number of
// packed BRAM rows and streams each row out as narrow elements over a
// valid/ready handshake. Lanes leave most-significant first.
//
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   start_i, num_rows_i   job request; sampled only while idle
//   addr_b_o, ce_b_o      BRAM read address / chip enable
//   we_b_o, d_b_o         BRAM write port, tied off (read-only client)
//   q_b_i                 BRAM read data, valid one cycle after ce_b_o
//   data_o, valid_o,      element stream towards the next layer's data mover
//   ready_i, last_o
//   busy_o, done_o        job status; done_o pulses once per completed job
// ----------------------------------------------------------------------------
module result_reader4 #(
    parameter int DWIDTH         = 32,
    parameter int AWIDTH         = 2,
    parameter int OUT_DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start_i,
    input  logic [AWIDTH:0]           num_rows_i,
    output logic [AWIDTH-1:0]         addr_b_o,
    output logic                      ce_b_o,
    output logic                      we_b_o,
    output logic [DWIDTH-1:0]         d_b_o,
    input  logic [DWIDTH-1:0]         q_b_i,
    output logic [OUT_DATA_WIDTH-1:0] data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      last_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int LANES = DWIDTH / OUT_DATA_WIDTH;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [LW-1:0]   LANE_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0]   LANE_ONE  = LW'(1);
    localparam logic [LW-1:0]   LAST_LANE = LW'(LANES - 1);
    localparam logic [AWIDTH:0] ROW_ZERO  = {(AWIDTH+1){1'b0}};
    localparam logic [AWIDTH:0] ROW_ONE   = (AWIDTH+1)'(1);
    localparam logic [AWIDTH:0] MAX_ROWS  = (AWIDTH+1)'(2**AWIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Lane 0 is the most-significant slice of the row.
    function automatic logic [OUT_DATA_WIDTH-1:0] lane_sel(
        input logic [DWIDTH-1:0] row,
        input logic [LW-1:0]     lane
    );
        logic [DWIDTH-1:0] shifted;
        shifted  = row << (OUT_DATA_WIDTH * int'(lane));
        lane_sel = shifted[DWIDTH-1 -: OUT_DATA_WIDTH];
    endfunction

    state_t                    r_state;
    logic [AWIDTH:0]           r_row_cnt;
    logic [AWIDTH:0]           r_rows_total;
    logic [LW-1:0]             r_lane;
    logic [DWIDTH-1:0]         r_buf;
    logic                      r_ce;
    logic [OUT_DATA_WIDTH-1:0] r_data;
    logic                      r_valid;
    logic                      r_last;
    logic                      r_busy;
    logic                      r_done;

    logic [AWIDTH:0]           w_rows_clamp;
    logic [AWIDTH:0]           w_row_next;
    logic [LW-1:0]             w_lane_next;
    logic                      w_on_last_row;

    // Requests beyond the memory depth are clamped to the whole memory.
    assign w_rows_clamp  = (num_rows_i > MAX_ROWS) ? MAX_ROWS : num_rows_i;
    assign w_row_next    = r_row_cnt + ROW_ONE;
    assign w_lane_next   = r_lane + LANE_ONE;
    assign w_on_last_row = (r_row_cnt == (r_rows_total - ROW_ONE));

    // The address simply tracks the row counter in every state.
    assign addr_b_o = r_row_cnt[AWIDTH-1:0];
    assign ce_b_o   = r_ce;
    assign we_b_o   = 1'b0;
    assign d_b_o    = {DWIDTH{1'b0}};
    assign data_o   = r_data;
    assign valid_o  = r_valid;
    assign last_o   = r_last;
    assign busy_o   = r_busy;
    assign done_o   = r_done;

    // Job FSM; every output is registered and set on the transition into the
    // state that owns it, so the outputs line up with the state cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_row_cnt    <= ROW_ZERO;
            r_rows_total <= ROW_ZERO;
            r_lane       <= LANE_ZERO;
            r_buf        <= {DWIDTH{1'b0}};
            r_ce         <= 1'b0;
            r_data       <= {OUT_DATA_WIDTH{1'b0}};
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_rows_total <= w_rows_clamp;
                        r_row_cnt    <= ROW_ZERO;
                        r_busy       <= 1'b1;
                        if (w_rows_clamp == ROW_ZERO) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                            r_ce    <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_READ: begin
                    r_state <= S_LATCH;
                    r_ce    <= 1'b0;
                end
                S_LATCH: begin
                    // Read data is present this cycle; the first lane goes
                    // straight to the output register.
                    r_buf   <= q_b_i;
                    r_lane  <= LANE_ZERO;
                    r_data  <= lane_sel(q_b_i, LANE_ZERO);
                    r_valid <= 1'b1;
                    r_last  <= (LAST_LANE == LANE_ZERO) && w_on_last_row;
                    r_state <= S_EMIT;
                end
                S_EMIT: begin
                    if (ready_i) begin
                        if (r_lane == LAST_LANE) begin
                            r_valid   <= 1'b0;
                            r_last    <= 1'b0;
                            r_lane    <= LANE_ZERO;
                            r_row_cnt <= w_row_next;
                            if (w_row_next < r_rows_total) begin
                                r_state <= S_READ;
                                r_ce    <= 1'b1;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_lane <= w_lane_next;
                            r_data <= lane_sel(r_buf, w_lane_next);
                            r_last <= (w_lane_next == LAST_LANE) && w_on_last_row;
                        end
                    end else begin
                        // Not accepted: hold the element stable.
                        r_state <= S_EMIT;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ce    <= 1'b0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_reader4.sv
module tb_result_reader4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_i;
    logic [2:0]  num_rows_i;
    logic [1:0]  addr_b_o;
    logic        ce_b_o;
    logic        we_b_o;
    logic [31:0] d_b_o;
    logic [31:0] q_b_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic        last_o;
    logic        busy_o;
    logic        done_o;

    result_reader4 dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (start_i),
        .num_rows_i (num_rows_i),
        .addr_b_o   (addr_b_o),
        .ce_b_o     (ce_b_o),
        .we_b_o     (we_b_o),
        .d_b_o      (d_b_o),
        .q_b_i      (q_b_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .last_o     (last_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [4];
    logic [7:0]  exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: one-cycle read latency; garbage when not enabled.
    always @(posedge clk) begin
        if (ce_b_o) q_b_i <= mem[addr_b_o];
        else        q_b_i <= $urandom;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"},  {30'd0, addr_b_o}, 32'd0);
        chk({tag, "_ce"},    {31'd0, ce_b_o},   32'd0);
        chk({tag, "_we"},    {31'd0, we_b_o},   32'd0);
        chk({tag, "_d"},     d_b_o,             32'd0);
        chk({tag, "_data"},  {24'd0, data_o},   32'd0);
        chk({tag, "_valid"}, {31'd0, valid_o},  32'd0);
        chk({tag, "_last"},  {31'd0, last_o},   32'd0);
        chk({tag, "_busy"},  {31'd0, busy_o},   32'd0);
        chk({tag, "_done"},  {31'd0, done_o},   32'd0);
    endtask

    // mode: 0 ready always high, 1 alternate on valid cycles starting low,
    // 2 random. exp_done: fixed done offset from T, or -1.
    // extra_start: cycle offset of an extra start pulse, or -1.
    task automatic run_job(input logic [2:0] n, input int mode, input int exp_done,
                           input int extra_start);
        int         t0, rows, stalls, reads, done_cyc;
        logic       tog, hold_pend, hl, hv, exp_last;
        logic [7:0] hd, e;
        exp_q.delete();
        rows = (n > 3'd4) ? 4 : int'(n);
        for (int r = 0; r < rows; r++)
            for (int l = 0; l < 4; l++)
                exp_q.push_back(8'((mem[r] >> (8 * (3 - l))) & 32'hFF));
        @(negedge clk);
        t0 = cyc;
        start_i = 1'b1; num_rows_i = n; ready_i = 1'b0;
        stalls = 0; reads = 0; done_cyc = -1; tog = 1'b0; hold_pend = 1'b0;
        hd = 8'd0; hl = 1'b0; hv = 1'b0;
        for (int k = 1; k <= 300 && done_cyc < 0; k++) begin
            @(negedge clk);
            start_i    = (k == extra_start);
            num_rows_i = (k == extra_start) ? 3'd2 : n;
            chk("we_tied", {31'd0, we_b_o}, 32'd0);
            chk("d_tied", d_b_o, 32'd0);
            chk("busy_job", {31'd0, busy_o}, 32'd1);
            if (hold_pend) begin
                chk("hold_valid", {31'd0, valid_o}, {31'd0, hv});
                chk("hold_data", {24'd0, data_o}, {24'd0, hd});
                chk("hold_last", {31'd0, last_o}, {31'd0, hl});
            end
            if (ce_b_o) begin
                chk("rd_addr", {30'd0, addr_b_o}, 32'(reads));
                chk("rd_cycle", 32'(cyc), 32'(t0 + 1 + 6 * reads + stalls));
                reads++;
            end
            if (done_o) done_cyc = cyc;
            case (mode)
                0:       ready_i = 1'b1;
                1:       begin if (valid_o) tog = ~tog; ready_i = valid_o ? ~tog : 1'b0; end
                default: ready_i = 1'($urandom_range(0, 1));
            endcase
            hold_pend = valid_o && !ready_i;
            hd = data_o; hl = last_o; hv = valid_o;
            if (valid_o && !ready_i) stalls++;
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("extra_elem", {24'd0, data_o}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    exp_last = (exp_q.size() == 0);
                    chk("elem", {24'd0, data_o}, {24'd0, e});
                    chk("last", {31'd0, last_o}, {31'd0, exp_last});
                end
            end
        end
        start_i = 1'b0;
        ready_i = 1'b0;
        if (done_cyc < 0) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("done_cycle", 32'(done_cyc), 32'(t0 + 1 + 6 * rows + stalls));
            if (exp_done >= 0) chk("done_fixed", 32'(done_cyc), 32'(t0 + exp_done));
        end
        chk("reads", 32'(reads), 32'(rows));
        chk("elems_left", 32'(exp_q.size()), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_busy", {31'd0, busy_o}, 32'd0);
            chk("idle_done", {31'd0, done_o}, 32'd0);
            chk("idle_valid", {31'd0, valid_o}, 32'd0);
            chk("idle_ce", {31'd0, ce_b_o}, 32'd0);
        end
    endtask

    typedef struct {
        logic [31:0] m0, m1, m2, m3;
        logic [2:0]  n;
        int          mode;
        int          exp_done;
        int          extra;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{32'hA1B2C3D4, 32'h0, 32'h0, 32'h0, 3'd1, 0, 7, -1};
        tbl[1] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F, 3'd4, 0, 25, -1};
        tbl[2] = '{32'hA1B2C3D4, 32'h0, 32'h0, 32'h0, 3'd1, 1, 11, -1};
        tbl[3] = '{32'h11223344, 32'h0, 32'h0, 32'h0, 3'd0, 0, 1, -1};
        tbl[4] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F, 3'd7, 0, 25, -1};
        tbl[5] = '{32'hA1B2C3D4, 32'h0, 32'h0, 32'h0, 3'd1, 0, 7, 4};

        reset_n = 1'b0; start_i = 1'b0; num_rows_i = 3'd0; ready_i = 1'b0;
        for (int r = 0; r < 4; r++) mem[r] = 32'd0;
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            mem[0] = tbl[i].m0; mem[1] = tbl[i].m1;
            mem[2] = tbl[i].m2; mem[3] = tbl[i].m3;
            run_job(tbl[i].n, tbl[i].mode, tbl[i].exp_done, tbl[i].extra);
        end

        // Reset during EMIT of row 1 of a 4-row job.
        mem[0] = 32'h00010203; mem[1] = 32'h04050607;
        mem[2] = 32'h08090A0B; mem[3] = 32'h0C0D0E0F;
        @(negedge clk);
        start_i = 1'b1; num_rows_i = 3'd4; ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_valid", {31'd0, valid_o}, 32'd1);
        chk("mid_data", {24'd0, data_o}, 32'h04);
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_done", {31'd0, done_o}, 32'd0);
        end
        ready_i = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done", {31'd0, done_o}, 32'd0);
        mem[0] = 32'hA1B2C3D4;
        run_job(3'd1, 0, 7, -1);

        // Randomized jobs against the stream model.
        for (int it = 0; it < 10; it++) begin
            for (int r = 0; r < 4; r++) mem[r] = $urandom;
            run_job(3'($urandom_range(0, 7)), 2, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_reader4.md
# result_reader4

Reads packed result rows back out of a BRAM and returns them as a stream of narrow elements; it is the read side of the FC1 result storage. Each DWIDTH-bit row holds DWIDTH/OUT_DATA_WIDTH elements, with the first element in the most-significant lane. The block walks a requested number of rows and emits elements MSB-lane first over a valid/ready handshake, feeding the next layer's data mover. The BRAM port is read-only from this block.

## Interface
- DWIDTH, 32, BRAM row width; must be an integer multiple of OUT_DATA_WIDTH
- AWIDTH, 2, BRAM address width
- OUT_DATA_WIDTH, 8, element width; LANES = DWIDTH/OUT_DATA_WIDTH (4 by default)

- clk  input  1  clock, rising edge
- reset_n  input  1  reset, asynchronous, active-low
- start_i  input  1  one-cycle start request; sampled only in IDLE
- num_rows_i  input  AWIDTH+1  number of rows to read; sampled with start_i
- addr_b_o  output  AWIDTH  BRAM address
- ce_b_o  output  1  BRAM chip enable
- we_b_o  output  1  BRAM write enable; constant 0
- d_b_o  output  DWIDTH  BRAM write data; constant 0
- q_b_i  input  DWIDTH  BRAM read data; valid one cycle after ce_b_o=1
- data_o  output  OUT_DATA_WIDTH  current element
- valid_o  output  1  data_o is valid
- ready_i  input  1  downstream accepts data_o when valid_o and ready_i are both 1
- last_o  output  1  high with valid_o on the final element of the job
- busy_o  output  1  high whenever state is not IDLE
- done_o  output  1  one-cycle pulse at job end

## Operation
- States:
  - IDLE, READ, LATCH, EMIT, DONE.
- Registers:
  - row counter row_cnt (AWIDTH+1 bits)
  - rows_total
  - lane counter (clog2(LANES) bits)
  - row buffer (DWIDTH bits)
- IDLE:
  - start_i=1 latches rows_total = min(num_rows_i, 2**AWIDTH) and sets row_cnt=0.
  - If rows_total=0, go to DONE; otherwise go to READ.
  - start_i is ignored in every other state.
- READ:
  - ce_b_o=1 and addr_b_o=row_cnt[AWIDTH-1:0].
  - Always goes to LATCH.
- LATCH:
  - The row buffer captures q_b_i, the lane counter clears, and the state goes to EMIT.
  - ce_b_o=0.
- EMIT:
  - valid_o=1 and data_o = row buffer lane (LANES-1-lane), so the first element comes from bits [DWIDTH-1 -: OUT_DATA_WIDTH].
  - On a handshake the lane counter increments.
  - On the handshake of lane LANES-1, row_cnt increments. The next state is READ if row_cnt+1 < rows_total, else DONE.
  - Without ready_i, data_o, valid_o and last_o hold stable.
- last_o = EMIT and lane = LANES-1 and row_cnt = rows_total-1.
- DONE: done_o=1 for one cycle, then IDLE.
- ce_b_o is high only in READ, and addr_b_o holds row_cnt[AWIDTH-1:0] in all states.
- Reset (asynchronous, any state):
  - state=IDLE, and all counters and the row buffer are cleared.
  - All outputs go to 0: addr_b_o, ce_b_o, we_b_o, d_b_o, data_o, valid_o, last_o, busy_o, done_o.
  - An in-flight job is abandoned and no done_o is generated for it.

## Timing
- Let start_i be sampled high in cycle T.
  - T+1: READ, ce_b_o=1, addr_b_o=0.
  - T+2: LATCH.
  - T+3: first valid_o.
- With ready_i held at 1, each row takes 6 cycles: READ, LATCH, then 4×EMIT.
  - Row k (0-based) is read at T+1+6k.
  - done_o pulses at T+1+6N for N rows.
  - For N=0, done_o pulses at T+1 and no BRAM access occurs.
- Each cycle ready_i is low during EMIT delays all later events by one cycle.
- There is no prefetch, so valid_o is low for 2 cycles between rows.
- busy_o rises at T+1 and falls in the cycle after done_o.
- A new start_i is accepted in the same cycle busy_o is low. That is at earliest the cycle after DONE.

## Test plan
- Single row:
  - Stimulus: BRAM[0]=0xA1B2C3D4, num_rows_i=1, ready_i=1.
  - Response: data_o is 0xA1, 0xB2, 0xC3, 0xD4 at T+3..T+6; last_o only with 0xD4; done_o at T+7.
- Full memory:
  - Stimulus: BRAM[0..3]=0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F, num_rows_i=4, ready_i=1.
  - Response: elements 0x00..0x0F in order; addr_b_o is 0,1,2,3 at T+1, T+7, T+13, T+19; done_o at T+25.
- Backpressure:
  - Stimulus: same as the single-row case, but ready_i alternates 0/1 starting at 0.
  - Response: data_o is stable while it is not accepted; each element is accepted exactly once; done_o is delayed by 4 cycles to T+11.
- Zero and clamp:
  - Stimulus 1: num_rows_i=0.
  - Response 1: done_o at T+1, ce_b_o never asserted.
  - Stimulus 2: num_rows_i=7.
  - Response 2: exactly 4 rows (16 elements) are read; addr_b_o never exceeds 3.
- Start while busy:
  - Stimulus: pulse start_i again at T+4 with num_rows_i=2 during a 1-row job.
  - Response: the pulse is ignored; one job, one done_o.
- Reset mid-job:
  - Stimulus: assert reset_n=0 during EMIT of row 1 in a 4-row job, then start a fresh 1-row job.
  - Response: all outputs are 0 immediately and no done_o is generated. The fresh job reads from addr 0 with the normal timing.
